// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential req/ack fetches into a DEPTH-entry {pc, instr} FIFO feeding decode.
// Optional FETCH_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int            CW      = $clog2(DEPTH);
    localparam logic [CW:0]   FULL    = (CW+1)'(DEPTH);
    localparam logic [CW:0]   ONE     = (CW+1)'(1);
    localparam logic [CW-1:0] PTR_ONE = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;
    logic [CW:0]   count_q, count_d, count_next;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];

    logic [31:0] redir_pc;
    logic        fifo_valid, bypass, pop_fifo, push, flush;

    assign redir_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign fifo_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = !fifo_valid && (state_q == REQ) && imem_ack && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = fifo_valid || bypass;
    assign out_pc    = fifo_valid ? pc_mem_q[rd_ptr_q]    : (bypass ? fetch_pc_q : 32'h0);
    assign out_instr = fifo_valid ? instr_mem_q[rd_ptr_q] : (bypass ? imem_rdata : 32'h0);

    assign pop_fifo  = fifo_valid && out_ready;
    // A bypassed word taken by decode this cycle never enters the FIFO.
    assign push      = (state_q == REQ) && imem_ack && !redirect && !(bypass && out_ready);
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

    always_comb begin
        count_next = count_q;
        case ({push, pop_fifo})
            2'b10:   count_next = count_q + ONE;
            2'b01:   count_next = count_q - ONE;
            default: count_next = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        count_d     = count_next;
        rd_ptr_d    = pop_fifo ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d    = push     ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        flush       = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                    flush      = 1'b1;
                    state_d    = REQ;
                end else if (count_q < FULL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d  = redir_pc;
                    flush       = 1'b1;
                    drop_addr_d = fetch_pc_q;
                    state_d     = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_next < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                // Outstanding stale request: keep its address until the ack retires it.
                if (redirect) fetch_pc_d = redir_pc;
                if (imem_ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]    = fetch_pc_q;
            instr_mem_d[wr_ptr_q] = imem_rdata;
        end
    end

    // State advances on the falling clock edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(negedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: directed fetch/redirect scenarios against a variable-latency memory.
module tb_instr_prefetch_queue;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          mem_lat = 0;
    int          ack_budget = 0;
    int          ack_cnt = 0;
    int          wcnt = 0;
    bit          late_ack = 1'b0;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_A5A5;
    endfunction

    // Memory model: acks after mem_lat waiting cycles while requests are pending and budget remains.
    always begin
        @(negedge clk);
        #2;
        imem_ack = 1'b0;
        if (late_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
            wcnt       = 0;
        end else if (!imem_req) begin
            wcnt = 0;
        end else if (wcnt >= mem_lat && ack_budget > 0) begin
            imem_ack   = 1'b1;
            imem_rdata = instr_of(imem_addr);
            wcnt       = 0;
            ack_budget--;
            ack_cnt++;
        end else if (wcnt < mem_lat) begin
            wcnt++;
        end
    end

    // Monitor: every accepted output must match the scoreboard head.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, scoreboard empty", out_pc, out_instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== instr_of(e)) begin
                    n_fail++;
                    $display("FAIL sb_entry: got pc=%h instr=%h expected pc=%h instr=%h",
                             out_pc, out_instr, e, instr_of(e));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect   = 1'b0;
        out_ready  = 1'b0;
        late_ack   = 1'b0;
        ack_budget = 0;
        mem_lat    = 0;
        step();
        step();
        ack_cnt = 0;
        exp_q.delete();
    endtask

    initial begin
        bit found;
        // Reset state
        do_reset();
        @(posedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        // Streaming: single-cycle memory, decode always ready
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        ack_budget = 8; out_ready = 1'b1; rst = 1'b0;
        @(posedge clk);
        chk("t1_idle_req", imem_req, 0);
        step(); @(posedge clk);
        chk("t1_first_req", imem_req, 1);
        chk("t1_first_addr", imem_addr, 32'h0);
        chk("t1_valid_ack_cycle", out_valid, BYP);
        step(); @(posedge clk);
        chk("t1_valid_after_ack", out_valid, 1);
        chk("t1_pc_after_ack", out_pc, BYP ? 32'h4 : 32'h0);
        wait_drain("t1_drain");

        // Full queue with decode stalled
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        ack_budget = 5; rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        @(posedge clk);
        chk("t2_full_req", imem_req, 0);
        chk("t2_full_acks", ack_cnt, 4);
        chk("t2_full_head", out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step(); @(posedge clk);
            if (imem_req) found = 1'b1;
        end
        chk("t2_rereq_seen", found, 1);
        chk("t2_rereq_addr", imem_addr, 32'h10);
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        wait_drain("t2_drain");

        // Redirect during a 3-cycle memory wait
        do_reset();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        mem_lat = 3; ack_budget = 3; out_ready = 1'b1; rst = 1'b0;
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        @(posedge clk);
        chk("t3_drop_req", imem_req, 1);
        chk("t3_drop_addr", imem_addr, 32'h0);
        chk("t3_drop_valid", out_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(); @(posedge clk);
            if (imem_ack) found = 1'b1;
        end
        chk("t3_drop_ack_seen", found, 1);
        step(); @(posedge clk);
        chk("t3_new_req", imem_req, 1);
        chk("t3_new_addr", imem_addr, 32'h100);
        wait_drain("t3_drain");

        // Redirect together with ack and pop, two entries queued
        do_reset();
        exp_q.push_back(32'h0);
        ack_budget = 3; rst = 1'b0;
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h2002; out_ready = 1'b1;
        @(posedge clk);
        chk("t4_pre_valid", out_valid, 1);
        chk("t4_pre_ack", imem_ack, 1);
        step();
        redirect = 1'b0;
        @(posedge clk);
        chk("t4_post_valid", out_valid, 0);
        chk("t4_post_req", imem_req, 1);
        chk("t4_post_addr", imem_addr, 32'h2000);
        step(); step(); step();
        @(posedge clk);
        chk("t4_still_empty", out_valid, 0);
        wait_drain("t4_drain");

        // Redirect from IDLE near the top of the address space, then wrap
        do_reset();
        exp_q.push_back(32'hFFFF_FFF4);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        ack_budget = 3; out_ready = 1'b1; rst = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4;
        step();
        redirect = 1'b0;
        @(posedge clk);
        chk("t5_start_addr", imem_addr, 32'hFFFF_FFF4);
        step(); step(); step();
        @(posedge clk);
        chk("t5_wrap_req", imem_req, 1);
        chk("t5_wrap_addr", imem_addr, 32'h0);
        wait_drain("t5_drain");

        // Reset mid-request, stray ack while idle
        do_reset();
        exp_q.push_back(32'h0);
        mem_lat = 3; ack_budget = 1; out_ready = 1'b1; rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; late_ack = 1'b1;
        @(posedge clk);
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_valid", out_valid, 0);
        step();
        late_ack = 1'b0;
        @(posedge clk);
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 32'h0);
        wait_drain("t6_drain");

`ifdef FETCH_BYPASS_EN
        // Zero-latency bypass into an empty queue
        do_reset();
        exp_q.push_back(32'h0);
        ack_budget = 1; out_ready = 1'b1; rst = 1'b0;
        step();
        @(posedge clk);
        chk("t7_byp_valid", out_valid, 1);
        chk("t7_byp_pc", out_pc, imem_addr);
        step();
        @(posedge clk);
        chk("t7_byp_empty", out_valid, 0);
        wait_drain("t7_drain");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
